// File: rtl/pulse_meas_scheduler_if.sv
// Result port of pulse_meas_scheduler: one per-channel edge count offered
// on a valid/ready handshake. The scheduler drives the master side; the
// measurement/register block consumes through the slave side.
interface pulse_meas_scheduler_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 32,
  parameter int CH_W  = $clog2(NCH)
);
  logic             res_valid;
  logic             res_ready;
  logic [CH_W-1:0]  res_ch;
  logic [CNT_W-1:0] res_cnt;
  logic             res_ovf;

  modport master (output res_valid, res_ch, res_cnt, res_ovf, input res_ready);
  modport slave  (input res_valid, res_ch, res_cnt, res_ovf, output res_ready);
endinterface

// File: rtl/pulse_meas_scheduler.sv
// pulse_meas_scheduler: sweeps the enabled pulse channels in ascending order,
// counting rising edges of the selected channel over a fixed gate window of
// cfg_win cycles, and offers each count on the result handshake.
// Optional build macro PULSE_SCHED_AUTO_EN: after the last channel of a sweep,
// restart at the lowest enabled channel instead of returning to IDLE.
module pulse_meas_scheduler #(
  parameter int NCH   = 4,
  parameter int CNT_W = 32,
  parameter int WIN_W = 16,
  parameter int CH_W  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] cfg_win,
  input  logic [NCH-1:0]   cfg_chmask,
  input  logic [NCH-1:0]   pulse_in,
  output logic             busy,
  output logic             sweep_done,
  pulse_meas_scheduler_if.master res
);

  typedef enum logic [2:0] {IDLE, ARM, COUNT, REPORT, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIN_W-1:0]   win_sh, win_left;
  logic [NCH-1:0]     mask_sh;
  logic [CH_W-1:0]    ch;
  logic               prev;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic               start_ok, rise, has_next;
  logic [CH_W-1:0]    first_cfg, first_sh, next_ch;

  // Degenerate configurations (no channel or empty window) never start a sweep.
  assign start_ok = start && (|cfg_chmask) && (|cfg_win);
  assign rise     = pulse_in[ch] & ~prev;

  // Lowest enabled channel of the live and shadowed masks; next enabled above ch.
  always_comb begin
    first_cfg = '0;
    first_sh  = '0;
    next_ch   = '0;
    has_next  = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cfg_chmask[i]) first_cfg = CH_W'(i);
      if (mask_sh[i])    first_sh  = CH_W'(i);
      if (mask_sh[i] && (i > int'(ch))) begin
        next_ch  = CH_W'(i);
        has_next = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs; abort overrides every transition.
  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    sweep_done = (state == DONE);
    case (state)
      IDLE:    if (start_ok) state_nxt = ARM;
      ARM:     state_nxt = COUNT;
      COUNT:   if (win_left == WIN_W'(1)) state_nxt = REPORT;
      REPORT:  if (res.res_ready) state_nxt = has_next ? ARM : DONE;
`ifdef PULSE_SCHED_AUTO_EN
      DONE:    state_nxt = ARM;
`else
      DONE:    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Shared datapath: config shadow, channel select, edge counter and window timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_sh   <= '0;
      mask_sh  <= '0;
      ch       <= '0;
      prev     <= 1'b0;
      cnt      <= '0;
      ovf      <= 1'b0;
      win_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok && !abort) begin
            win_sh  <= cfg_win;
            mask_sh <= cfg_chmask;
            ch      <= first_cfg;
          end
        end
        ARM: begin
          // Sampling the level here means a channel already high is not an edge.
          prev     <= pulse_in[ch];
          cnt      <= '0;
          ovf      <= 1'b0;
          win_left <= win_sh;
        end
        COUNT: begin
          prev     <= pulse_in[ch];
          win_left <= win_left - WIN_W'(1);
          if (rise) begin
            if (&cnt) ovf <= 1'b1;
            else      cnt <= cnt + CNT_W'(1);
          end
        end
        REPORT: begin
          if (res.res_ready && has_next) ch <= next_ch;
        end
        DONE: begin
`ifdef PULSE_SCHED_AUTO_EN
          ch <= first_sh;
`endif
        end
        default: ;
      endcase
    end
  end

  // Result fields come straight from the registers, which only change outside REPORT.
  assign res.res_valid = (state == REPORT);
  assign res.res_ch    = ch;
  assign res.res_cnt   = cnt;
  assign res.res_ovf   = ovf;

endmodule

// File: tb/tb_pulse_meas_scheduler.sv
// Scoreboard bench for pulse_meas_scheduler: expected results are queued as
// each sweep is launched and popped when the DUT completes a handshake.
// A second instance with a 4-bit counter exercises saturation.
module tb_pulse_meas_scheduler;
  localparam int NCH = 4, CNT_W = 32, WIN_W = 16, CH_W = 2;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [WIN_W-1:0] cfg_win = '0;
  logic [NCH-1:0]   cfg_chmask = '0, pulse_in = '0, tog = '0;
  logic             busy, sweep_done, busy4, done4;

  pulse_meas_scheduler_if #(.NCH(NCH), .CNT_W(CNT_W)) rif ();
  pulse_meas_scheduler_if #(.NCH(NCH), .CNT_W(4))     rif4 ();
  assign rif4.res_ready = rif.res_ready;

  always #5 clk = ~clk;

  pulse_meas_scheduler #(.NCH(NCH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_win(cfg_win),
    .cfg_chmask(cfg_chmask), .pulse_in(pulse_in), .busy(busy),
    .sweep_done(sweep_done), .res(rif));

  pulse_meas_scheduler #(.NCH(NCH), .CNT_W(4), .WIN_W(WIN_W)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_win(cfg_win),
    .cfg_chmask(cfg_chmask), .pulse_in(pulse_in), .busy(busy4),
    .sweep_done(done4), .res(rif4));

  typedef struct {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0, n_fail = 0, n_done = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: count sweep_done pulses, score every accepted result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sweep_done) n_done++;
      if (rif.res_valid && rif.res_ready) begin
        if (sb.size() == 0) chk("sb_unexpected", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("res_ch",  64'(rif.res_ch),  64'(e.ch));
          chk("res_cnt", 64'(rif.res_cnt), 64'(e.cnt));
          chk("res_ovf", 64'(rif.res_ovf), 64'(e.ovf));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    pulse_in = pulse_in ^ tog;
  endtask

  task automatic push(input int c, input int n, input bit o);
    exp_t x;
    x.ch = CH_W'(c); x.cnt = CNT_W'(n); x.ovf = o;
    sb.push_back(x);
  endtask

  task automatic start_sweep(input logic [NCH-1:0] m, input int w);
    cfg_chmask = m; cfg_win = WIN_W'(w); start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin step(); n++; end while (!rif.res_valid && n < budget);
    if (!rif.res_valid) chk("timeout_valid", 64'd0, 64'd1);
  endtask

  task automatic finish_sweep();
    step();
    chk("sweep_done_hi", 64'(sweep_done), 64'd1);
    step();
    chk("sweep_done_lo", 64'(sweep_done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, d0, drops;
    rif.res_ready = 1'b0;
    step(); step();
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_valid", 64'(rif.res_valid), 64'd0);
    chk("rst_cnt",   64'(rif.res_cnt), 64'd0);
    chk("rst_ch",    64'(rif.res_ch), 64'd0);
    chk("rst_ovf",   64'(rif.res_ovf), 64'd0);
    chk("rst_done",  64'(sweep_done), 64'd0);
    rst_n = 1'b1;
    step();

    // Two channels, ch0 toggling; config change and start while busy ignored.
    rif.res_ready = 1'b1; tog = 4'b0011;
    push(0, 5, 0); push(2, 0, 0);
    start_sweep(4'b0101, 10);
    cfg_chmask = 4'b1111; cfg_win = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(40, n); chk("lat_ch0", 64'(n + 2), 64'd12);
    wait_valid(40, n); chk("lat_ch2", 64'(n), 64'd12);
    finish_sweep();

    // Level already high at ARM is not an edge; one rise inside window counts.
    tog = '0; pulse_in = 4'b0010;
    push(1, 0, 0);
    start_sweep(4'b0010, 8);
    wait_valid(40, n);
    finish_sweep();
    pulse_in = '0;
    push(1, 1, 0);
    start_sweep(4'b0010, 8);
    step(); step(); step();
    pulse_in[1] = 1'b1;
    wait_valid(40, n);
    finish_sweep();
    pulse_in = '0;

    // 20 edges: full-width counter exact, 4-bit counter saturates with ovf.
    tog = 4'b0001;
    push(0, 20, 0);
    start_sweep(4'b0001, 40);
    wait_valid(100, n);
    chk("ovf4_valid", 64'(rif4.res_valid), 64'd1);
    chk("ovf4_cnt",   64'(rif4.res_cnt), 64'd15);
    chk("ovf4_flag",  64'(rif4.res_ovf), 64'd1);
    finish_sweep();

    // Back-pressure: result held stable, next channel waits for handshake.
    rif.res_ready = 1'b0;
    push(0, 3, 0); push(2, 0, 0);
    start_sweep(4'b0101, 6);
    wait_valid(40, n); chk("lat_stall", 64'(n + 1), 64'd8);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("stall_valid", 64'(rif.res_valid), 64'd1);
      chk("stall_ch",    64'(rif.res_ch), 64'd0);
      chk("stall_cnt",   64'(rif.res_cnt), 64'd3);
    end
    rif.res_ready = 1'b1;
    step();
    chk("hs_valid_drop", 64'(rif.res_valid), 64'd0);
    chk("hs_busy",       64'(busy), 64'd1);
    wait_valid(40, n); chk("lat_after_hs", 64'(n), 64'd7);
    finish_sweep();

    // Abort during COUNT of channel 1.
    tog = 4'b0011;
    push(0, 3, 0);
    start_sweep(4'b0011, 6);
    wait_valid(40, n);
    step(); step(); step();
    d0 = n_done;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy",  64'(busy), 64'd0);
    chk("abort_valid", 64'(rif.res_valid), 64'd0);
    for (int i = 0; i < 10; i++) step();
    chk("abort_no_valid", 64'(rif.res_valid), 64'd0);
    chk("abort_no_done",  64'(n_done - d0), 64'd0);

    // Degenerate starts and abort+start.
    cfg_chmask = '0; cfg_win = 16'd5; start = 1'b1;
    step(); start = 1'b0;
    chk("mask0_busy", 64'(busy), 64'd0);
    cfg_chmask = 4'b0001; cfg_win = '0; start = 1'b1;
    step(); start = 1'b0;
    chk("win0_busy", 64'(busy), 64'd0);
    cfg_win = 16'd5; start = 1'b1; abort = 1'b1;
    step(); start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 64'(busy), 64'd0);
    step();
    chk("degenerate_no_done", 64'(n_done - d0), 64'd0);

    // Reset while a result is pending.
    tog = 4'b0100; rif.res_ready = 1'b0;
    start_sweep(4'b0100, 4);
    wait_valid(40, n);
    chk("pre_rst_ch",  64'(rif.res_ch), 64'd2);
    chk("pre_rst_cnt", 64'(rif.res_cnt), 64'd2);
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy",  64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(rif.res_valid), 64'd0);
    chk("mid_rst_ch",    64'(rif.res_ch), 64'd0);
    chk("mid_rst_cnt",   64'(rif.res_cnt), 64'd0);
    chk("mid_rst_ovf",   64'(rif.res_ovf), 64'd0);
    chk("mid_rst_done",  64'(sweep_done), 64'd0);
    rst_n = 1'b1; tog = '0; pulse_in = '0;
    step();
    chk("post_rst_busy", 64'(busy), 64'd0);

`ifdef PULSE_SCHED_AUTO_EN
    // Continuous sweeping: two full sweeps with busy never dropping.
    tog = 4'b0001; rif.res_ready = 1'b1;
    push(0, 2, 0); push(1, 0, 0); push(0, 2, 0); push(1, 0, 0);
    d0 = n_done; drops = 0;
    start_sweep(4'b0011, 4);
    for (int i = 0; i < 60 && (n_done - d0) < 2; i++) begin
      step();
      if (!busy) drops++;
    end
    chk("auto_busy_drops", 64'(drops), 64'd0);
    chk("auto_done_cnt",   64'(n_done - d0), 64'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("auto_abort_busy", 64'(busy), 64'd0);
`else
    drops = 0;
`endif

    step(); step();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
